mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage placed between the execute stage and the writeback stage. It accepts an instruction once the execute stage has completed the address handshake on the data SRAM bus. It waits for the matching data_ok response, then aligns and sign- or zero-extends load data. It forwards the result to writeback and to the decode-stage bypass network, and it discards responses that belong to flushed instructions.

Parameters:
DISCARD_CNT_W, 2, width of the outstanding-discard counter; supports up to 2^DISCARD_CNT_W-1 orphaned responses.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  exception/ertn flush from CSR unit; kills MEM contents
ex_to_mem_valid  in  1  upstream instruction valid
mem_allow_in  out  1  stage can accept an instruction this cycle
in_pc  in  32  instruction PC
in_alu_result  in  32  ALU result / memory byte address
in_ld_size  in  2  00 byte, 01 half, 10 word (loads only)
in_ld_signed  in  1  sign-extend load data
in_is_load  in  1  instruction is a load
in_mem_req  in  1  a data SRAM request was issued (load or store)
in_dest  in  5  destination GPR
in_gr_we  in  1  GPR write enable
in_ex  in  1  instruction carries an exception or is ertn
data_sram_data_ok  in  1  read/write response
data_sram_rdata  in  32  read data
wb_allow_in  in  1  writeback stage can accept
mem_to_wb_valid  out  1  result valid to writeback
out_pc  out  32  PC to writeback
out_result  out  32  final GPR write data
out_dest  out  5  destination GPR
out_gr_we  out  1  GPR write enable
out_ex  out  1  exception flag to writeback
mem_ex  out  1  MEM holds a valid excepting instruction; used by upstream to suppress new SRAM requests
fwd_dest  out  5  bypass destination; 0 when invalid
fwd_data  out  32  bypass data (= out_result)
fwd_block  out  1  consumer must stall: load data not yet usable

Behaviour:
- Registers: mem_valid, payload, data_ok_seen, rdata_buf[31:0], discard_cnt.
- Reset or flush: mem_valid=0, data_ok_seen=0. Reset only: discard_cnt=0. All outputs are deasserted while mem_valid=0 (fwd_dest=0, fwd_block=0, mem_ex=0, mem_to_wb_valid=0).
- Capture: when mem_allow_in && ex_to_mem_valid, load the payload, set mem_valid=1 and clear data_ok_seen.
- mem_allow_in = ~mem_valid | (ready_go & wb_allow_in). Also forced 0 during flush.
- ready_go = ~in_mem_req(reg) | data_ok_seen | (data_sram_data_ok && discard_cnt==0).
- Response routing:
  - data_ok with discard_cnt>0: decrement discard_cnt. The response is dropped and never counts for the current instruction.
  - Otherwise, data_ok while mem_valid && mem_req && ~data_ok_seen: capture rdata_buf and set data_ok_seen=1. Data is usable the same cycle through the bypass.
- Flush while mem_valid && mem_req && ~data_ok_seen && no data_ok that cycle: discard_cnt += 1.
- Flush in the same cycle as data_ok: the response is consumed and no increment occurs.
- Upstream requests already address-accepted but not yet captured are the upstream's responsibility: upstream reports them via in_mem_req when they reach MEM. If upstream is flushed in the same cycle, it does not increment here.
- discard_cnt saturates; overflow is a design error flagged by assertion.
- Load extraction uses shift = alu_result[1:0]*8 and data = (data_ok_seen ? rdata_buf : data_sram_rdata) >> shift.
  - byte: 8 bits, sign- or zero-extended
  - half: 16 bits, extended (address is 2-byte aligned)
  - word: 32 bits unchanged
- out_result = is_load ? load_data : alu_result.
- Stores: data_ok is awaited the same way, but out_result = alu_result.
- Excepting instructions (in_ex=1) never have in_mem_req=1. They pass through with ready_go=1, and mem_ex=mem_valid&in_ex.
- fwd_block = mem_valid & is_load & ~(data_ok_seen | (data_ok & discard_cnt==0)), unless MEM_FWD_LOAD_EN is undefined (see below).
- Latency: non-memory instruction 1 cycle; memory instruction 1 cycle + data_ok wait.
- Held result: the output holds stable while wb_allow_in=0, and a buffered response is not lost.

Optional Feature:
MEM_FWD_LOAD_EN
- Defined: load data is bypassed as soon as data_ok is observed, with fwd_block as specified above.
- Undefined: fwd_block = mem_valid & is_load for the whole time the load is in MEM; fwd_data is not relied upon for loads.

Test Plan:
- ALU instruction, in_alu_result=0x1234_5678, wb_allow_in=1 -> next cycle mem_to_wb_valid=1, out_result=0x12345678, fwd_block=0.
- ld.b signed at addr 0x...03, data_ok after 3 cycles with rdata=0x80FF_0000 -> out_result=0xFFFFFF80; ld.bu at the same address -> 0x00000080; fwd_block drops the same cycle as data_ok (feature on).
- ld.h signed at addr 0x...02, rdata=0x8001_1234 -> out_result=0xFFFF8001. data_ok arrives while wb_allow_in=0 -> result held, emitted when wb_allow_in=1, value unchanged.
- Load waiting, flush asserted, next instruction enters, stale data_ok (rdata=0xDEADBEEF) arrives -> discard_cnt 1->0, stale data ignored, new load completes only on its own data_ok.
- Flush in the same cycle as data_ok -> discard_cnt stays 0, mem_valid=0 next cycle.
- Excepting instruction in MEM -> mem_ex=1, no wait on data_ok, passes with out_ex=1. Reset mid-wait -> all outputs 0, discard_cnt=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundles the MEM stage pipeline, data SRAM response, bypass and flush signals.
// Signal names follow the pipeline-wide naming of the surrounding core.
//   slave  : seen from mem_stage (consumes EX payload / SRAM response, drives WB/bypass)
//   master : seen from the environment driving mem_stage
interface mem_stage_if;
    // Control
    logic        flush;
    // EX -> MEM handshake and payload
    logic        ex_to_mem_valid;
    logic        mem_allow_in;
    logic [31:0] in_pc;
    logic [31:0] in_alu_result;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic        in_is_load;
    logic        in_mem_req;
    logic [4:0]  in_dest;
    logic        in_gr_we;
    logic        in_ex;
    // Data SRAM response channel
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    // MEM -> WB handshake and payload
    logic        wb_allow_in;
    logic        mem_to_wb_valid;
    logic [31:0] out_pc;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_gr_we;
    logic        out_ex;
    // Upstream request suppression and decode bypass
    logic        mem_ex;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        fwd_block;

    modport slave (
        input  flush, ex_to_mem_valid, in_pc, in_alu_result, in_ld_size, in_ld_signed,
               in_is_load, in_mem_req, in_dest, in_gr_we, in_ex,
               data_sram_data_ok, data_sram_rdata, wb_allow_in,
        output mem_allow_in, mem_to_wb_valid, out_pc, out_result, out_dest, out_gr_we,
               out_ex, mem_ex, fwd_dest, fwd_data, fwd_block
    );

    modport master (
        output flush, ex_to_mem_valid, in_pc, in_alu_result, in_ld_size, in_ld_signed,
               in_is_load, in_mem_req, in_dest, in_gr_we, in_ex,
               data_sram_data_ok, data_sram_rdata, wb_allow_in,
        input  mem_allow_in, mem_to_wb_valid, out_pc, out_result, out_dest, out_gr_we,
               out_ex, mem_ex, fwd_dest, fwd_data, fwd_block
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB.
// Holds one instruction, waits for its data SRAM data_ok, aligns and extends load
// data, and forwards the result to WB and the decode bypass. Responses owed to
// flushed instructions are counted and dropped when they arrive.
//
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus_io : mem_stage_if.slave (EX payload, SRAM response, WB payload, bypass, flush)
//
// Parameters:
//   DISCARD_CNT_W : width of the orphaned-response counter (max 2^W-1 outstanding)
//
// Build option:
//   MEM_FWD_LOAD_EN : when defined, load data is bypassed in the cycle data_ok is seen;
//                     otherwise fwd_block stays high for a load's whole MEM residency.
module mem_stage #(
    parameter int unsigned DISCARD_CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus_io
);

    localparam logic [DISCARD_CNT_W-1:0] DiscardMax = '1;

    logic                     mem_valid_q, mem_valid_d;
    logic                     data_ok_seen_q, data_ok_seen_d;
    logic [31:0]              rdata_buf_q, rdata_buf_d;
    logic [DISCARD_CNT_W-1:0] discard_cnt_q, discard_cnt_d;

    // Payload only matters while mem_valid_q is set, so it carries no reset.
    logic [31:0] pc_q;
    logic [31:0] alu_result_q;
    logic [1:0]  ld_size_q;
    logic        ld_signed_q;
    logic        is_load_q;
    logic        mem_req_q;
    logic [4:0]  dest_q;
    logic        gr_we_q;
    logic        ex_q;

    logic        discard_idle;
    logic        resp_live;
    logic        resp_drop;
    logic        waiting;
    logic        ready_go;
    logic        allow_in;
    logic        capture;
    logic        orphan_new;
    logic [31:0] rdata_sel;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] result;

    always_comb begin
        discard_idle = (discard_cnt_q == '0);
        // A response belongs to the resident instruction only when no orphan is owed.
        resp_live    = bus_io.data_sram_data_ok & discard_idle;
        resp_drop    = bus_io.data_sram_data_ok & ~discard_idle;
        waiting      = mem_valid_q & mem_req_q & ~data_ok_seen_q;
        ready_go     = ~mem_req_q | data_ok_seen_q | resp_live;
        allow_in     = ~bus_io.flush & (~mem_valid_q | (ready_go & bus_io.wb_allow_in));
        capture      = allow_in & bus_io.ex_to_mem_valid;
        // Killing a still-waiting instruction leaves its response in flight.
        orphan_new   = bus_io.flush & waiting & ~resp_live;
    end

    always_comb begin
        mem_valid_d    = mem_valid_q;
        data_ok_seen_d = data_ok_seen_q;
        rdata_buf_d    = rdata_buf_q;
        discard_cnt_d  = discard_cnt_q;

        if (bus_io.flush) begin
            mem_valid_d = 1'b0;
        end else if (allow_in) begin
            mem_valid_d = bus_io.ex_to_mem_valid;
        end

        if (bus_io.flush || allow_in) begin
            data_ok_seen_d = 1'b0;
        end else if (waiting && resp_live) begin
            data_ok_seen_d = 1'b1;
            rdata_buf_d    = bus_io.data_sram_rdata;
        end

        // A dropped orphan and a freshly orphaned request in one cycle cancel out.
        case ({orphan_new, resp_drop})
            2'b10:   discard_cnt_d = (discard_cnt_q == DiscardMax) ? discard_cnt_q
                                                                   : discard_cnt_q + 1'b1;
            2'b01:   discard_cnt_d = discard_cnt_q - 1'b1;
            default: discard_cnt_d = discard_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q    <= 1'b0;
            data_ok_seen_q <= 1'b0;
            rdata_buf_q    <= '0;
            discard_cnt_q  <= '0;
        end else begin
            mem_valid_q    <= mem_valid_d;
            data_ok_seen_q <= data_ok_seen_d;
            rdata_buf_q    <= rdata_buf_d;
            discard_cnt_q  <= discard_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            pc_q         <= bus_io.in_pc;
            alu_result_q <= bus_io.in_alu_result;
            ld_size_q    <= bus_io.in_ld_size;
            ld_signed_q  <= bus_io.in_ld_signed;
            is_load_q    <= bus_io.in_is_load;
            mem_req_q    <= bus_io.in_mem_req;
            dest_q       <= bus_io.in_dest;
            gr_we_q      <= bus_io.in_gr_we;
            ex_q         <= bus_io.in_ex;
        end
    end

    // Load alignment: the live response is usable in the cycle it arrives.
    always_comb begin
        rdata_sel = data_ok_seen_q ? rdata_buf_q : bus_io.data_sram_rdata;
        shifted   = rdata_sel >> {alu_result_q[1:0], 3'b000};
        case (ld_size_q)
            2'b00:   load_data = {{24{ld_signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{ld_signed_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
        result = is_load_q ? load_data : alu_result_q;
    end

    always_comb begin
        bus_io.mem_allow_in    = allow_in;
        bus_io.mem_to_wb_valid = mem_valid_q & ready_go;
        bus_io.out_pc          = mem_valid_q ? pc_q : '0;
        bus_io.out_result      = mem_valid_q ? result : '0;
        bus_io.out_dest        = mem_valid_q ? dest_q : '0;
        bus_io.out_gr_we       = mem_valid_q & gr_we_q;
        bus_io.out_ex          = mem_valid_q & ex_q;
        bus_io.mem_ex          = mem_valid_q & ex_q;
        bus_io.fwd_dest        = mem_valid_q ? dest_q : '0;
        bus_io.fwd_data        = mem_valid_q ? result : '0;
`ifdef MEM_FWD_LOAD_EN
        bus_io.fwd_block       = mem_valid_q & is_load_q & ~(data_ok_seen_q | resp_live);
`else
        bus_io.fwd_block       = mem_valid_q & is_load_q;
`endif
    end

`ifndef SYNTHESIS
    // More orphaned responses than the counter can track.
    discard_overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(orphan_new && !resp_drop && discard_cnt_q == DiscardMax));
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [1:0]  size;
        logic        sgn;
        logic        is_load;
        logic        mem_req;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ex;
    } instr_t;

    // One owed data_ok from the memory, returned in request order.
    typedef struct {
        logic [31:0] rdata;
        int          due;
        int          id;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    resp_t       resp_q[$];
    logic        m_valid;
    instr_t      m_ins;
    logic        m_done;
    int          m_id;
    int          next_id;
    logic [31:0] m_exp;
    int          cyc;

    // Per-cycle stimulus knobs
    logic        k_vin;
    logic        k_flush;
    logic        k_wb;
    instr_t      k_ins;
    int          k_delay;
    logic [31:0] k_rdata;

    logic [31:0] last_wb_result;
    int          wb_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] load_value(input instr_t i, input logic [31:0] word);
        int         off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(i.alu[1:0]);
        b   = word[off*8 +: 8];
        h   = word[(off & 2)*8 +: 16];
        case (i.size)
            2'd0:    return i.sgn ? 32'($signed(b)) : 32'(b);
            2'd1:    return i.sgn ? 32'($signed(h)) : 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic instr_t blank_instr();
        instr_t i;
        i.pc = 32'h0; i.alu = 32'h0; i.size = 2'd0; i.sgn = 1'b0; i.is_load = 1'b0;
        i.mem_req = 1'b0; i.dest = 5'd0; i.gr_we = 1'b0; i.ex = 1'b0;
        return i;
    endfunction

    function automatic instr_t mk_alu(input logic [31:0] alu, input logic ex);
        instr_t i = blank_instr();
        i.pc = 32'h1c00_0040; i.alu = alu; i.dest = 5'd7; i.gr_we = ~ex; i.ex = ex;
        return i;
    endfunction

    function automatic instr_t mk_load(input logic [31:0] addr, input logic [1:0] size,
                                       input logic sgn);
        instr_t i = blank_instr();
        i.pc = 32'h1c00_0100; i.alu = addr; i.size = size; i.sgn = sgn;
        i.is_load = 1'b1; i.mem_req = 1'b1; i.dest = 5'd12; i.gr_we = 1'b1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i = blank_instr();
        int kind = $urandom_range(0, 9);
        i.pc    = $urandom;
        i.pc[1:0] = 2'b00;
        i.alu   = $urandom;
        i.sgn   = 1'($urandom_range(0, 1));
        i.dest  = 5'($urandom_range(0, 31));
        i.gr_we = 1'b1;
        if (kind < 4) begin
            i.is_load = 1'b1;
            i.mem_req = 1'b1;
            i.size    = 2'($urandom_range(0, 2));
            if (i.size == 2'd1) i.alu[0] = 1'b0;
            if (i.size == 2'd2) i.alu[1:0] = 2'b00;
        end else if (kind < 6) begin
            i.mem_req = 1'b1;
            i.gr_we   = 1'b0;
        end else if (kind == 6) begin
            i.ex = 1'b1;
        end
        return i;
    endfunction

    task automatic knobs_idle();
        k_vin = 1'b0; k_flush = 1'b0; k_wb = 1'b1; k_ins = blank_instr();
        k_delay = 0; k_rdata = 32'h0;
    endtask

    task automatic knobs_rand();
        k_flush = ($urandom_range(0, 15) == 0) && (resp_q.size() <= 2);
        k_vin   = !k_flush && ($urandom_range(0, 9) < 7);
        k_wb    = ($urandom_range(0, 3) != 0);
        k_ins   = rand_instr();
        k_delay = $urandom_range(0, 5);
        k_rdata = $urandom;
    endtask

    task automatic drive_inputs(input logic dok, input logic [31:0] rdata);
        bus.flush             = k_flush;
        bus.ex_to_mem_valid   = k_vin;
        bus.in_pc             = k_ins.pc;
        bus.in_alu_result     = k_ins.alu;
        bus.in_ld_size        = k_ins.size;
        bus.in_ld_signed      = k_ins.sgn;
        bus.in_is_load        = k_ins.is_load;
        bus.in_mem_req        = k_ins.mem_req;
        bus.in_dest           = k_ins.dest;
        bus.in_gr_we          = k_ins.gr_we;
        bus.in_ex             = k_ins.ex;
        bus.wb_allow_in       = k_wb;
        bus.data_sram_data_ok = dok;
        bus.data_sram_rdata   = rdata;
    endtask

    // One clock cycle: drive at negedge, check #1 later, then advance the model.
    task automatic step();
        logic  resp_now;
        logic  own_now;
        logic  exp_done;
        logic  exp_allow;
        logic  exp_blk;
        resp_t r;
        @(negedge clk);
        resp_now = (resp_q.size() > 0) && (resp_q[0].due <= cyc);
        drive_inputs(resp_now, resp_now ? resp_q[0].rdata : $urandom);
        #1;
        own_now   = resp_now && m_valid && (resp_q[0].id == m_id);
        exp_done  = m_valid && (!m_ins.mem_req || m_done || own_now);
        exp_allow = !k_flush && (!m_valid || (exp_done && k_wb));
`ifdef MEM_FWD_LOAD_EN
        exp_blk   = m_valid && m_ins.is_load && !(m_done || own_now);
`else
        exp_blk   = m_valid && m_ins.is_load;
`endif
        check_eq("mem_allow_in", 32'(bus.mem_allow_in), 32'(exp_allow));
        check_eq("mem_to_wb_valid", 32'(bus.mem_to_wb_valid), 32'(exp_done));
        check_eq("mem_ex", 32'(bus.mem_ex), 32'(m_valid && m_ins.ex));
        check_eq("fwd_dest", 32'(bus.fwd_dest), m_valid ? 32'(m_ins.dest) : 32'h0);
        check_eq("fwd_block", 32'(bus.fwd_block), 32'(exp_blk));
        if (exp_done) begin
            check_eq("out_result", bus.out_result, m_exp);
            check_eq("out_pc", bus.out_pc, m_ins.pc);
            check_eq("out_dest", 32'(bus.out_dest), 32'(m_ins.dest));
            check_eq("out_gr_we", 32'(bus.out_gr_we), 32'(m_ins.gr_we));
            check_eq("out_ex", 32'(bus.out_ex), 32'(m_ins.ex));
`ifndef MEM_FWD_LOAD_EN
            if (!m_ins.is_load)
`endif
                check_eq("fwd_data", bus.fwd_data, m_exp);
            if (k_wb) begin
                last_wb_result = bus.out_result;
                wb_count++;
            end
        end
        // Advance the model to the state after the coming edge.
        if (resp_now) begin
            if (own_now) m_done = 1'b1;
            void'(resp_q.pop_front());
        end
        if (k_flush) begin
            m_valid = 1'b0;
        end else if (exp_allow) begin
            m_valid = k_vin;
            if (k_vin) begin
                next_id++;
                m_id   = next_id;
                m_ins  = k_ins;
                m_done = 1'b0;
                m_exp  = k_ins.is_load ? load_value(k_ins, k_rdata) : k_ins.alu;
                if (k_ins.mem_req) begin
                    r.rdata = k_rdata;
                    r.due   = cyc + 1 + k_delay;
                    r.id    = m_id;
                    resp_q.push_back(r);
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        knobs_idle();
        drive_inputs(1'b0, 32'h0);
        @(negedge clk);
        #1;
        check_eq("rst_to_wb_valid", 32'(bus.mem_to_wb_valid), 32'h0);
        check_eq("rst_mem_ex", 32'(bus.mem_ex), 32'h0);
        check_eq("rst_fwd_dest", 32'(bus.fwd_dest), 32'h0);
        check_eq("rst_fwd_block", 32'(bus.fwd_block), 32'h0);
        check_eq("rst_out_result", bus.out_result, 32'h0);
        check_eq("rst_out_pc", bus.out_pc, 32'h0);
        check_eq("rst_out_gr_we", 32'(bus.out_gr_we), 32'h0);
        check_eq("rst_out_ex", 32'(bus.out_ex), 32'h0);
        reset   = 1'b0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        resp_q.delete();
        cyc += 2;
    endtask

    // Idle upstream until the resident instruction retires, then check its value.
    task automatic run_until_wb(input string tag, input logic [31:0] exp);
        int start = wb_count;
        for (int n = 0; n < 30 && wb_count == start; n++) begin
            knobs_idle();
            step();
        end
        check_eq({tag, "_retired"}, 32'(wb_count - start), 32'h1);
        check_eq(tag, last_wb_result, exp);
    endtask

    task automatic issue(input instr_t ins, input int delay, input logic [31:0] rdata,
                         input logic wb);
        knobs_idle();
        k_vin = 1'b1; k_ins = ins; k_delay = delay; k_rdata = rdata; k_wb = wb;
        step();
    endtask

    initial begin
        reset = 1'b1;
        m_valid = 1'b0; m_done = 1'b0; m_id = 0; next_id = 0; m_exp = 32'h0; cyc = 0;
        m_ins = blank_instr(); last_wb_result = 32'h0; wb_count = 0;
        knobs_idle();
        drive_inputs(1'b0, 32'h0);
        do_reset();

        // Plain ALU instruction
        issue(mk_alu(32'h1234_5678, 1'b0), 0, 32'h0, 1'b1);
        run_until_wb("alu", 32'h1234_5678);

        // Byte loads at offset 3
        issue(mk_load(32'h0000_1003, 2'd0, 1'b1), 2, 32'h80FF_0000, 1'b1);
        run_until_wb("ld_b", 32'hFFFF_FF80);
        issue(mk_load(32'h0000_1003, 2'd0, 1'b0), 2, 32'h80FF_0000, 1'b1);
        run_until_wb("ld_bu", 32'h0000_0080);

        // Half load whose data_ok arrives while WB is stalled
        issue(mk_load(32'h0000_2002, 2'd1, 1'b1), 1, 32'h8001_1234, 1'b1);
        for (int n = 0; n < 5; n++) begin
            knobs_idle();
            k_wb = 1'b0;
            step();
        end
        run_until_wb("ld_h_held", 32'hFFFF_8001);

        // Flush a waiting load; its late response must not reach the next load
        issue(mk_load(32'h0000_3000, 2'd2, 1'b0), 4, 32'hDEAD_BEEF, 1'b1);
        knobs_idle();
        step();
        knobs_idle();
        k_flush = 1'b1;
        step();
        issue(mk_load(32'h0000_3004, 2'd2, 1'b0), 0, 32'h1357_9BDF, 1'b1);
        run_until_wb("stale_drop", 32'h1357_9BDF);

        // Flush coincides with the load's own data_ok: nothing is left owed
        issue(mk_load(32'h0000_4000, 2'd2, 1'b0), 1, 32'hCAFE_0001, 1'b1);
        knobs_idle();
        step();
        knobs_idle();
        k_flush = 1'b1;
        step();
        issue(mk_load(32'h0000_4004, 2'd2, 1'b0), 0, 32'h2468_ACE0, 1'b1);
        run_until_wb("flush_dok", 32'h2468_ACE0);

        // Excepting instruction passes without a memory wait
        issue(mk_alu(32'h0000_ABCD, 1'b1), 0, 32'h0, 1'b0);
        knobs_idle();
        k_wb = 1'b0;
        step();
        run_until_wb("except", 32'h0000_ABCD);

        // Reset while a load waits, then a fresh load completes on its own response
        issue(mk_load(32'h0000_5000, 2'd2, 1'b0), 5, 32'h1111_2222, 1'b1);
        knobs_idle();
        step();
        do_reset();
        issue(mk_load(32'h0000_5001, 2'd0, 1'b0), 0, 32'h0000_5A00, 1'b1);
        run_until_wb("post_reset", 32'h0000_005A);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            knobs_rand();
            step();
        end
        // Drain so every owed response is delivered
        for (int n = 0; n < 40; n++) begin
            knobs_idle();
            step();
        end
        check_eq("drain_empty", 32'(resp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
